rpn_sequencer: RTL and testbench
================================

// Module: rpn_sequencer
// PURPOSE
//  Program-driven master for the stack calculator `main`. Holds a small RPN program
//  {op,operand} loaded over a write port. On `start`, issues each instruction to the
//  calculator over its op/in/apply interface, checks `valid` after every apply and
//  reports the final `head` as `result`. Sits between host/testbench logic and `main`.
// PARAMETERS
//  W      16  data width; must match the W of `main`
//  DEPTH  16  program memory entries (power of two)
//  AW     4   program address width, log2(DEPTH)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  prog_we    in   1      program write strobe, honoured only in IDLE/DONE/ERR
//  prog_addr  in   AW     program write address
//  prog_data  in   W+4    {op[3:0], operand[W-1:0]}
//  start      in   1      run request, 1-cycle pulse, ignored while busy
//  busy       out  1      run in progress (ISSUE/CHECK)
//  done       out  1      level; run ended normally, held until next start
//  error      out  1      level; run aborted, held until next start
//  result     out  W      head captured at halt
//  err_pc     out  AW     pc of the failing instruction
//  op         out  4      to main.op
//  in         out  W      to main.in
//  apply      out  1      to main.apply
//  head       in   W      from main.head
//  empty      in   1      from main.empty; informational only
//  valid      in   1      from main.valid
// BEHAVIOUR
//  - Reset (rst=0) forces state IDLE and clears pc, busy, done, error, result,
//    err_pc, apply and op/in to 0. The reset is asynchronous and may abort a run.
//    Program memory is not cleared.
//  - Op codes follow `main`: 0 inc, 1 dec, 2 add, 3 sub, 4 mul, 5 op5, 6 mod,
//    7 push operand, 8 pop. F halt. 9..E are illegal.
//  - States: IDLE, ISSUE, CHECK, DONE, ERR.
//  - IDLE/DONE/ERR + start: pc<=0, clear done/error, go to ISSUE. A prog_we in the
//    same cycle is written first.
//  - ISSUE (1 cycle), decode mem[pc] combinationally:
//      - halt: result<=head, go to DONE. No apply is issued.
//      - illegal: err_pc<=pc, go to ERR. No apply is issued.
//      - otherwise: apply=1, op/in=word; `main` updates on this edge. Go to CHECK.
//  - CHECK (1 cycle), apply=0:
//      - valid=0: err_pc<=pc, go to ERR.
//      - pc==DEPTH-1: result<=head, go to DONE (implicit halt).
//      - otherwise: pc<=pc+1, go to ISSUE.
//  - Each issued op costs 2 cycles. apply is never high in two consecutive cycles.
//  - In DONE/ERR, op, in and apply are 0.
//  - busy = ISSUE|CHECK. Stack arithmetic wraps mod 2^W inside `main`; no checking
//    is done here.
//  - start and prog_we while busy are dropped silently. The program cannot change
//    mid-run.
//  - pc does not wrap; the run ends at the last entry.
// CONFIGURATION
//  RPN_SEQ_CYCLE_CNT_EN defined:
//   - adds output `run_cycles[15:0]`: 0 on reset/start, +1 every busy cycle,
//     saturating at FFFF, frozen in DONE/ERR.
//  Undefined: the port and counter are absent; other behaviour is identical.
// TESTING (calculator = real `main`, reset pulsed low before each scenario)
//  1. push 300, push 150, push 2, add, halt -> done=1, result=152, error=0,
//     apply seen exactly 4 times; run_cycles=9 with EN.
//  2. push 300, push 148, mul, halt -> result=44400. push 300, push 7, mod,
//     halt -> result=6.
//  3. push 5, word 4'hA at pc1 -> error=1, err_pc=1, apply seen once, result=0.
//  4. pop on empty stack at pc0 (main drops valid) -> error=1, err_pc=0, busy=0.
//  5. 16 pushes of 1..16, no halt -> done after pc15, result=16, pc not wrapped.
//  6. rst low during CHECK of a run -> all outputs 0 immediately. start pulse while
//     busy and prog_we while busy -> no effect on the run or the memory.

Source files
------------

// File: rtl/rpn_sequencer.sv
// rtl/rpn_sequencer.sv - program-driven RPN master for the `main` stack calculator
// Optional run-cycle counter enabled by defining RPN_SEQ_CYCLE_CNT_EN.
module rpn_sequencer #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [W+3:0]  prog_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [W-1:0]  result,
    output logic [AW-1:0] err_pc,
    output logic [3:0]    op,
    output logic [W-1:0]  in,
    output logic          apply,
    input  logic [W-1:0]  head,
    input  logic          empty,
    input  logic          valid
`ifdef RPN_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]   run_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] pc, pc_next;
    logic [W-1:0]  result_next;
    logic [AW-1:0] err_pc_next;

    logic [W+3:0]  mem [DEPTH];
    logic [W+3:0]  word;
    logic [3:0]    word_op;
    logic [W-1:0]  word_operand;
    logic          is_halt;
    logic          is_illegal;

    // The stack status flag carries no information the sequencer needs.
    logic          unused_empty;
    assign unused_empty = empty;

    assign busy  = (state == ISSUE) || (state == CHECK);
    assign done  = (state == DONE);
    assign error = (state == ERR);

    // Writes are locked out during a run so the program is stable mid-run.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign word         = mem[pc];
    assign word_op      = word[W+3:W];
    assign word_operand = word[W-1:0];
    assign is_halt      = (word_op == 4'hF);
    assign is_illegal   = (word_op >= 4'h9) && (word_op <= 4'hE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= '0;
            result <= '0;
            err_pc <= '0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            result <= result_next;
            err_pc <= err_pc_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        result_next = result;
        err_pc_next = err_pc;
        op          = 4'd0;
        in          = '0;
        apply       = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (is_halt) begin
                    result_next = head;
                    state_next  = DONE;
                end else if (is_illegal) begin
                    err_pc_next = pc;
                    state_next  = ERR;
                end else begin
                    apply      = 1'b1;
                    op         = word_op;
                    in         = word_operand;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                // `main` has already absorbed the apply; valid reflects that op.
                if (!valid) begin
                    err_pc_next = pc;
                    state_next  = ERR;
                end else if (pc == AW'(DEPTH - 1)) begin
                    result_next = head;
                    state_next  = DONE;
                end else begin
                    pc_next    = pc + 1'b1;
                    state_next = ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef RPN_SEQ_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cycles <= 16'd0;
        end else if (!busy && start) begin
            run_cycles <= 16'd0;
        end else if (busy && (run_cycles != 16'hFFFF)) begin
            run_cycles <= run_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb/tb_rpn_sequencer.sv - self-checking bench for rpn_sequencer with a behavioural `main`
module tb_rpn_sequencer;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] result;
    logic [3:0]  err_pc;
    logic [3:0]  op;
    logic [15:0] in;
    logic        apply;
    logic [15:0] head;
    logic        empty;
    logic        valid;
`ifdef RPN_SEQ_CYCLE_CNT_EN
    logic [15:0] run_cycles;
`endif

    int total = 0;
    int bad   = 0;

    logic [19:0] prog [16];

    rpn_sequencer #(.W(16), .DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .result    (result),
        .err_pc    (err_pc),
        .op        (op),
        .in        (in),
        .apply     (apply),
        .head      (head),
        .empty     (empty),
        .valid     (valid)
`ifdef RPN_SEQ_CYCLE_CNT_EN
        ,
        .run_cycles(run_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the `main` calculator: 16-deep stack, valid flags the last apply.
    logic [15:0] stk [16];
    int          sp;
    logic        cvalid;

    function automatic logic [15:0] bin_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a * b;
            4'd5:    return a ^ b;
            default: return a % b;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp     <= 0;
            cvalid <= 1'b1;
        end else if (apply) begin
            case (op)
                4'd0, 4'd1: begin
                    if (sp >= 1) begin
                        stk[sp-1] <= (op == 4'd0) ? stk[sp-1] + 16'd1 : stk[sp-1] - 16'd1;
                        cvalid    <= 1'b1;
                    end else cvalid <= 1'b0;
                end
                4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                    if (sp >= 2 && !(op == 4'd6 && stk[sp-1] == 16'd0)) begin
                        stk[sp-2] <= bin_op(op, stk[sp-2], stk[sp-1]);
                        sp        <= sp - 1;
                        cvalid    <= 1'b1;
                    end else cvalid <= 1'b0;
                end
                4'd7: begin
                    if (sp < 16) begin
                        stk[sp] <= in;
                        sp      <= sp + 1;
                        cvalid  <= 1'b1;
                    end else cvalid <= 1'b0;
                end
                4'd8: begin
                    if (sp >= 1) begin
                        sp     <= sp - 1;
                        cvalid <= 1'b1;
                    end else cvalid <= 1'b0;
                end
                default: cvalid <= 1'b0;
            endcase
        end
    end

    assign head  = (sp == 0) ? 16'd0 : stk[sp-1];
    assign empty = (sp == 0);
    assign valid = cvalid;

    function automatic logic [19:0] mk(input logic [3:0] o, input logic [15:0] v);
        return {o, v};
    endfunction

    // Program-level reference: walk the list with a queue stack and plain arithmetic.
    task automatic ref_run(output bit e_done, output bit e_err, output logic [15:0] e_res,
                           output logic [3:0] e_pc, output int e_app, output int e_cyc);
        logic [15:0] q[$];
        logic [15:0] a, b, v;
        logic [3:0]  o;
        e_done = 0; e_err = 0; e_res = 16'd0; e_pc = 4'd0; e_app = 0; e_cyc = 0;
        for (int p = 0; p < 16; p++) begin
            o = prog[p][19:16];
            v = prog[p][15:0];
            e_cyc++;
            if (o == 4'hF) begin
                e_done = 1; e_res = (q.size() > 0) ? q[$] : 16'd0;
                return;
            end
            if (o >= 4'h9) begin
                e_err = 1; e_pc = 4'(p);
                return;
            end
            e_app++;
            e_cyc++;
            if (o == 4'd7) begin
                if (q.size() >= 16) begin e_err = 1; e_pc = 4'(p); return; end
                q.push_back(v);
            end else if (o == 4'd8 || o <= 4'd1) begin
                if (q.size() < 1) begin e_err = 1; e_pc = 4'(p); return; end
                a = q.pop_back();
                if (o == 4'd0) q.push_back(a + 16'd1);
                if (o == 4'd1) q.push_back(a - 16'd1);
            end else begin
                if (q.size() < 2 || (o == 4'd6 && q[$] == 16'd0)) begin
                    e_err = 1; e_pc = 4'(p); return;
                end
                b = q.pop_back();
                a = q.pop_back();
                case (o)
                    4'd2:    q.push_back(16'((32'(a) + 32'(b)) % 65536));
                    4'd3:    q.push_back(16'((32'(a) + 65536 - 32'(b)) % 65536));
                    4'd4:    q.push_back(16'((32'(a) * 32'(b)) % 65536));
                    4'd5:    q.push_back(a ^ b);
                    default: q.push_back(16'(32'(a) % 32'(b)));
                endcase
            end
            if (p == 15) begin
                e_done = 1; e_res = (q.size() > 0) ? q[$] : 16'd0;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; prog_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fill_prog(input logic [19:0] w);
        for (int i = 0; i < 16; i++) prog[i] = w;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic run_prog(input bit inject, output int napp, output int ncyc,
                            output bit b2b, output bit tout);
        bit prev;
        napp = 0; ncyc = 0; b2b = 0; tout = 1; prev = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            start = 1'b0; prog_we = 1'b0;
            if (apply) napp++;
            if (apply && prev) b2b = 1;
            prev = apply;
            if (busy) ncyc++;
            if (done || error) begin tout = 0; break; end
            if (inject && ncyc == 3) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = 4'd3; prog_data = 20'hA0000;
            end
            @(negedge clk);
        end
        start = 1'b0; prog_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({busy, done, error, result, err_pc, op, in, apply} !== 44'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b error=%b result=%0d err_pc=%0d op=%0d in=%0d apply=%b, want all 0",
                     busy, done, error, result, err_pc, op, in, apply);
        end
    endtask

    task automatic test_basic_add();
        int na, nc; bit bb, to;
        do_reset();
        fill_prog(mk(4'hF, 16'd0));
        prog[0] = mk(4'd7, 16'd300); prog[1] = mk(4'd7, 16'd150);
        prog[2] = mk(4'd7, 16'd2);   prog[3] = mk(4'd2, 16'd0);
        load_prog();
        run_prog(0, na, nc, bb, to);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout: run never ended"); end
        total++;
        if ({done, error} !== 2'b10) begin bad++; $display("FAIL basic_status: got done=%b error=%b, want done=1 error=0", done, error); end
        total++;
        if (result !== 16'd152) begin bad++; $display("FAIL basic_result: got %0d, want 152", result); end
        total++;
        if (na !== 4) begin bad++; $display("FAIL basic_applies: got %0d, want 4", na); end
        total++;
        if (bb !== 1'b0) begin bad++; $display("FAIL basic_b2b_apply: apply high in consecutive cycles"); end
        total++;
        if (nc !== 9) begin bad++; $display("FAIL basic_busy_cycles: got %0d, want 9", nc); end
`ifdef RPN_SEQ_CYCLE_CNT_EN
        total++;
        if (run_cycles !== 16'd9) begin bad++; $display("FAIL basic_run_cycles: got %0d, want 9", run_cycles); end
`endif
        total++;
        if ({op, in, apply} !== 21'd0) begin bad++; $display("FAIL basic_idle_bus: got op=%0d in=%0d apply=%b, want 0", op, in, apply); end
    endtask

    task automatic test_arith();
        int na, nc; bit bb, to;
        do_reset();
        fill_prog(mk(4'hF, 16'd0));
        prog[0] = mk(4'd7, 16'd300); prog[1] = mk(4'd7, 16'd148); prog[2] = mk(4'd4, 16'd0);
        load_prog();
        run_prog(0, na, nc, bb, to);
        total++;
        if (result !== 16'd44400 || done !== 1'b1) begin bad++; $display("FAIL arith_mul: got result=%0d done=%b, want 44400 done=1", result, done); end
        do_reset();
        prog[1] = mk(4'd7, 16'd7); prog[2] = mk(4'd6, 16'd0);
        load_prog();
        run_prog(0, na, nc, bb, to);
        total++;
        if (result !== 16'd6 || done !== 1'b1) begin bad++; $display("FAIL arith_mod: got result=%0d done=%b, want 6 done=1", result, done); end
    endtask

    task automatic test_illegal();
        int na, nc; bit bb, to;
        do_reset();
        fill_prog(mk(4'hF, 16'd0));
        prog[0] = mk(4'd7, 16'd5); prog[1] = mk(4'hA, 16'd0);
        load_prog();
        run_prog(0, na, nc, bb, to);
        total++;
        if ({done, error} !== 2'b01) begin bad++; $display("FAIL illegal_status: got done=%b error=%b, want 0/1", done, error); end
        total++;
        if (err_pc !== 4'd1) begin bad++; $display("FAIL illegal_err_pc: got %0d, want 1", err_pc); end
        total++;
        if (na !== 1 || result !== 16'd0) begin bad++; $display("FAIL illegal_applies_result: got applies=%0d result=%0d, want 1/0", na, result); end
    endtask

    task automatic test_underflow();
        int na, nc; bit bb, to;
        do_reset();
        fill_prog(mk(4'hF, 16'd0));
        prog[0] = mk(4'd8, 16'd0);
        load_prog();
        run_prog(0, na, nc, bb, to);
        total++;
        if ({error, err_pc, busy} !== 6'b1_0000_0) begin bad++; $display("FAIL underflow: got error=%b err_pc=%0d busy=%b, want 1/0/0", error, err_pc, busy); end
    endtask

    task automatic test_full_program();
        int na, nc; bit bb, to;
        do_reset();
        for (int i = 0; i < 16; i++) prog[i] = mk(4'd7, 16'(i + 1));
        load_prog();
        run_prog(0, na, nc, bb, to);
        total++;
        if ({done, error} !== 2'b10 || result !== 16'd16) begin bad++; $display("FAIL full_program: got done=%b error=%b result=%0d, want 1/0/16", done, error, result); end
        total++;
        if (na !== 16 || nc !== 32) begin bad++; $display("FAIL full_no_wrap: got applies=%0d busy_cycles=%0d, want 16/32", na, nc); end
    endtask

    task automatic test_reset_abort();
        bit seen;
        do_reset();
        fill_prog(mk(4'hF, 16'd0));
        prog[0] = mk(4'd7, 16'd1); prog[1] = mk(4'd7, 16'd2); prog[2] = mk(4'd2, 16'd0);
        load_prog();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (apply) seen = 1;
            @(negedge clk);
        end
        total++;
        if (!(seen && busy && !apply)) begin bad++; $display("FAIL abort_setup: not in CHECK (seen=%b busy=%b apply=%b)", seen, busy, apply); end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({busy, done, error, result, err_pc, op, in, apply} !== 44'd0) begin
            bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b error=%b result=%0d op=%0d in=%0d apply=%b, want all 0",
                     busy, done, error, result, op, in, apply);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_busy_ignore();
        int na, nc; bit bb, to;
        do_reset();
        fill_prog(mk(4'hF, 16'd0));
        prog[0] = mk(4'd7, 16'd10); prog[1] = mk(4'd7, 16'd20); prog[2] = mk(4'd7, 16'd30);
        prog[3] = mk(4'd2, 16'd0);  prog[4] = mk(4'd2, 16'd0);
        load_prog();
        run_prog(1, na, nc, bb, to);
        total++;
        if ({done, error} !== 2'b10 || result !== 16'd60 || na !== 5) begin
            bad++; $display("FAIL busy_inject_run: got done=%b error=%b result=%0d applies=%0d, want 1/0/60/5", done, error, result, na);
        end
        do_reset();
        run_prog(0, na, nc, bb, to);
        total++;
        if ({done, error} !== 2'b10 || result !== 16'd60) begin
            bad++; $display("FAIL busy_mem_kept: got done=%b error=%b result=%0d, want 1/0/60", done, error, result);
        end
    endtask

    task automatic test_random();
        int na, nc, ea, ec, r;
        bit bb, to, ed, ee;
        logic [15:0] eres;
        logic [3:0]  epc;
        for (int it = 0; it < 25; it++) begin
            do_reset();
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(0, 99);
                if (r < 45)      prog[i] = mk(4'd7, 16'($urandom_range(0, 65535)));
                else if (r < 55) prog[i] = mk(4'd2, 16'd0);
                else if (r < 63) prog[i] = mk(4'd3, 16'd0);
                else if (r < 70) prog[i] = mk(4'd4, 16'd0);
                else if (r < 75) prog[i] = mk(4'd6, 16'd0);
                else if (r < 82) prog[i] = mk(4'($urandom_range(0, 1)), 16'd0);
                else if (r < 88) prog[i] = mk(4'd8, 16'd0);
                else if (r < 92) prog[i] = mk(4'($urandom_range(9, 14)), 16'd0);
                else             prog[i] = mk(4'hF, 16'($urandom_range(0, 65535)));
            end
            load_prog();
            ref_run(ed, ee, eres, epc, ea, ec);
            run_prog(0, na, nc, bb, to);
            total++;
            if (to || done !== ed || error !== ee || busy !== 1'b0) begin
                bad++; $display("FAIL rand_status[%0d]: got done=%b error=%b busy=%b timeout=%b, want %b/%b/0/0", it, done, error, busy, to, ed, ee);
            end
            total++;
            if (result !== eres || (ee && err_pc !== epc)) begin
                bad++; $display("FAIL rand_result[%0d]: got result=%0d err_pc=%0d, want %0d/%0d", it, result, err_pc, eres, epc);
            end
            total++;
            if (na !== ea || nc !== ec || bb) begin
                bad++; $display("FAIL rand_timing[%0d]: got applies=%0d cycles=%0d b2b=%b, want %0d/%0d/0", it, na, nc, bb, ea, ec);
            end
`ifdef RPN_SEQ_CYCLE_CNT_EN
            total++;
            if (run_cycles !== 16'(ec)) begin bad++; $display("FAIL rand_run_cycles[%0d]: got %0d, want %0d", it, run_cycles, ec); end
`endif
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 20'd0;
        test_reset();
        test_basic_add();
        test_arith();
        test_illegal();
        test_underflow();
        test_full_program();
        test_reset_abort();
        test_busy_ignore();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
